// File: rtl/rns_mod21_sched_pkg.sv
// Shared definitions for the mod-21 RNS forward-conversion front end.
package rns_pkg;

  localparam int MOD21   = 21;
  localparam int CHUNK_W = 6;
  localparam int PART_W  = 9;
  localparam int RES21_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    CORR = 2'd2,
    OUT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rns_mod21_sched_fold.sv
// First-level mod-21 reduction: 64 == 1 (mod 21), so the sum of the 6-bit
// chunks of the operand is congruent to the operand (max 5*63 + 3 = 318).
module mod21_fold
  import rns_pkg::*;
(
  input  logic [31:0]       n,
  output logic [PART_W-1:0] part
);

  // Pure chunk sum; all terms zero-extended to the partial width.
  always_comb begin
    part = PART_W'(n[CHUNK_W-1:0])
         + PART_W'(n[2*CHUNK_W-1:CHUNK_W])
         + PART_W'(n[3*CHUNK_W-1:2*CHUNK_W])
         + PART_W'(n[4*CHUNK_W-1:3*CHUNK_W])
         + PART_W'(n[5*CHUNK_W-1:4*CHUNK_W])
         + PART_W'(n[31:5*CHUNK_W]);
  end

endmodule

// File: rtl/rns_mod21_sched.sv
// Round-robin scheduler sharing one mod-21 reduction datapath among NREQ
// requesters. Each accepted operand walks FOLD -> CORR -> OUT before the
// next one is taken, so at most one operand is in flight.
module rns_mod21_sched
  import rns_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [RES21_W-1:0]   res_data,
  output logic [ID_W-1:0]      res_id,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  sched_state_t        state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     id_reg;
  logic [ID_W-1:0]     gidx;
  logic [NREQ-1:0]     grant;
  logic                accept;
  logic [31:0]         sel_op;
  logic [31:0]         op_reg;
  logic [PART_W-1:0]   part_reg;
  logic [PART_W-1:0]   fold_sum;

  // Second fold plus the two conditional subtractions: f <= 67, so after
  // removing 42 and then 21 at most once each the value lands in 0..20.
  function automatic logic [RES21_W-1:0] corr21(input logic [PART_W-1:0] p);
    logic [6:0] f;
    f = 7'(p[8:6]) + 7'(p[5:0]);
    if (f >= 7'(2 * MOD21)) f = f - 7'(2 * MOD21);
    if (f >= 7'(MOD21))     f = f - 7'(MOD21);
    return f[RES21_W-1:0];
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ID_W'((int'(last_grant) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  // Accept strobe is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = (rst_n && state == IDLE) ? grant : '0;
    accept    = |req_ready;
    sel_op    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) sel_op = req_data[32*j +: 32];
    end
  end

  mod21_fold u_fold (
    .n    (op_reg),
    .part (fold_sum)
  );

  // Operand datapath registers; their contents are don't-care until used.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      op_reg <= sel_op;
      id_reg <= gidx;
    end
    if (state == FOLD) part_reg <= fold_sum;
  end

  // Scheduler FSM with registered result channel, busy flag and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NREQ - 1);
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
      busy       <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= gidx;
            busy       <= 1'b1;
            state      <= FOLD;
          end
        end
        FOLD: begin
          state <= CORR;
        end
        CORR: begin
          res_data  <= corr21(part_reg);
          res_id    <= id_reg;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_mod21_sched.sv
// Directed bench for rns_mod21_sched: residues, latency, round-robin order,
// backpressure and mid-operation reset.
module tb_rns_mod21_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic [4:0]         res_data;
  logic [ID_W-1:0]    res_id;
  logic               res_ready;
  logic               busy;
  logic [15:0]        done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rns_mod21_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Returns number of negedges waited (first call point counts as 1).
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_one(input int r, input logic [31:0] d, input logic [4:0] exp, input string tag);
    int lat;
    logic [NREQ-1:0] onehot;
    onehot = NREQ'(1) << r;
    req_data[32*r +: 32] = d;
    req_valid = onehot;
    res_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid = '0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_res(lat);
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_data"}, 32'(res_data), 32'(exp));
    check({tag, "_id"}, 32'(res_id), r);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int ids[5];
    logic [4:0] exps[5];
    ids  = '{0, 1, 2, 3, 0};
    exps = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd16};

    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with all requests pending
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, all-ones operand: partial 318 -> f 66 -> 3
    run_one(0, 32'hFFFF_FFFF, 5'd3, "r0_ffff");
    check("done_after_1", 32'(done_cnt), 32'd1);

    // Sequential requests from requester 1
    run_one(1, 32'd0, 5'd0, "r1_0");
    run_one(1, 32'd20, 5'd20, "r1_20");
    run_one(1, 32'd21, 5'd0, "r1_21");
    run_one(1, 32'd1000, 5'd13, "r1_1000");
    run_one(1, 32'h7FFF_FFFF, 5'd1, "r1_7fff");
    check("done_after_6", 32'(done_cnt), 32'd6);

    // Round robin with all requesters pending, from a fresh reset
    pulse_reset();
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'(100 + i);
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_res(lat);
      if (k > 0) check($sformatf("rr_interval_%0d", k), lat, 32'd4);
      check($sformatf("rr_id_%0d", k), 32'(res_id), ids[k]);
      check($sformatf("rr_data_%0d", k), 32'(res_data), 32'(exps[k]));
      if (k == 4) req_valid = '0;
      @(negedge clk);
    end
    check("rr_done_cnt", 32'(done_cnt), 32'd5);
    check("rr_idle", 32'(busy), 32'd0);

    // Backpressure: requester 3 result held while requester 0 waits
    req_data[32*3 +: 32] = 32'd1000;
    req_valid = 4'b1000;
    res_ready = 1'b0;
    #1;
    check("bp_grant3", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_res(lat);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("bp_data_%0d", c), 32'(res_data), 32'd13);
      check($sformatf("bp_id_%0d", c), 32'(res_id), 32'd3);
      check($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(res_valid), 32'd0);
    check("bp_release_cnt", 32'(done_cnt), 32'd6);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_ready0", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);

    // Reset while in CORR discards the operand
    req_data[32*1 +: 32] = 32'd20;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    pulse_reset();
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(done_cnt), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mid_rst_quiet_%0d", c), 32'(res_valid), 32'd0);
      @(negedge clk);
    end

    // After reset, requester 2 wins over requester 3
    req_data[32*2 +: 32] = 32'd50;
    req_data[32*3 +: 32] = 32'd60;
    req_valid = 4'b1100;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b1000;
    wait_res(lat);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_id2", 32'(res_id), 32'd2);
    check("post_rst_data2", 32'(res_data), 32'd8);
    @(negedge clk);
    wait_res(lat);
    req_valid = '0;
    check("post_rst_id3", 32'(res_id), 32'd3);
    check("post_rst_data3", 32'(res_data), 32'd18);
    @(negedge clk);
    check("post_rst_cnt", 32'(done_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
